// File: rtl/ram256_wb_port_if.sv
// ============================================================================
// Module  : ram256_wb_port_if
// Brief   : Wishbone-classic signal bundle between the SoC interconnect and
//           the RAM256 bus port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ram256_wb_port_if #(
  parameter int WSIZE = 4
);
  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic               wb_we_i;
  logic [WSIZE-1:0]   wb_sel_i;
  logic [31:0]        wb_adr_i;
  logic [WSIZE*8-1:0] wb_dat_i;
  logic [WSIZE*8-1:0] wb_dat_o;
  logic               wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

`default_nettype wire

// File: rtl/ram256_wb_port.sv
// ============================================================================
// Module  : ram256_wb_port
// Brief   : Wishbone-classic slave driving one RAM256 port; one RAM cycle per
//           transfer, registered ack. Define RAM256_WB_ZERO_INIT_EN to zero-fill
//           the array after reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram256_wb_port #(
  parameter int          WSIZE     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00
) (
  input  wire logic               wb_clk_i,
  input  wire logic               wb_rst_i,
  ram256_wb_port_if.slave         wb,
  output logic                    ram_en0,
  output logic [WSIZE-1:0]        ram_we0,
  output logic [7:0]              ram_a0,
  output logic [WSIZE*8-1:0]      ram_di0,
  input  wire logic [WSIZE*8-1:0] ram_do0,
  output logic                    init_done
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   we_q, we_d;
  logic   w_hit;
  logic   w_req;

`ifdef RAM256_WB_ZERO_INIT_EN
  localparam state_t c_reset_state = ST_INIT;
  logic [7:0] cnt_q, cnt_d;
  assign init_done = (state_q != ST_INIT);
`else
  localparam state_t c_reset_state = ST_IDLE;
  assign init_done = 1'b1;
`endif

  assign w_hit = ((wb.wb_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_req = wb.wb_cyc_i & wb.wb_stb_i & w_hit;

  // Ack is a pure function of the state register, so it is registered.
  assign wb.wb_ack_o = (state_q == ST_ACK);
  assign wb.wb_dat_o = ((state_q == ST_ACK) && !we_q) ? ram_do0 : '0;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ram_en0 = 1'b0;
    ram_we0 = '0;
    ram_a0  = '0;
    ram_di0 = '0;
`ifdef RAM256_WB_ZERO_INIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef RAM256_WB_ZERO_INIT_EN
        ram_en0 = 1'b1;
        ram_we0 = '1;
        ram_a0  = cnt_q;
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (w_req) begin
          ram_en0 = 1'b1;
          ram_a0  = wb.wb_adr_i[9:2];
          ram_di0 = wb.wb_dat_i;
          ram_we0 = wb.wb_we_i ? wb.wb_sel_i : '0;
          we_d    = wb.wb_we_i;
          state_d = ST_ACK;
        end
      end
      // Always return to IDLE so a lingering strobe is not issued twice.
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Nothing reaches the RAM while reset is held.
    if (wb_rst_i) begin
      ram_en0 = 1'b0;
      ram_we0 = '0;
      ram_a0  = '0;
      ram_di0 = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= c_reset_state;
      we_q    <= 1'b0;
`ifdef RAM256_WB_ZERO_INIT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
`ifdef RAM256_WB_ZERO_INIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram256_wb_port.sv
// ============================================================================
// Module  : tb_ram256_wb_port
// Brief   : Self-checking bench for ram256_wb_port with a RAM256 model and a
//           word-array reference memory.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram256_wb_port;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] MASK = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en0;
  logic [3:0]  ram_we0;
  logic [7:0]  ram_a0;
  logic [31:0] ram_di0;
  logic [31:0] ram_do0;
  logic        init_done;

  always #5 clk = ~clk;

  ram256_wb_port_if #(.WSIZE(4)) wb ();

  ram256_wb_port #(
    .WSIZE     (4),
    .BASE_ADDR (BASE),
    .ADDR_MASK (MASK)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (wb),
    .ram_en0   (ram_en0),
    .ram_we0   (ram_we0),
    .ram_a0    (ram_a0),
    .ram_di0   (ram_di0),
    .ram_do0   (ram_do0),
    .init_done (init_done)
  );

  // RAM256 behaviour: synchronous, byte-write, read-before-write
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_en0) begin
      ram_do0 <= ram_mem[ram_a0];
      for (int b = 0; b < 4; b++)
        if (ram_we0[b]) ram_mem[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
    end
  end

  // Reference memory: what each word should hold, and whether it is known
  logic [31:0] ref_mem [256];
  bit          ref_ok  [256];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic idle_bus();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'h0;
    wb.wb_adr_i = 32'h0;
    wb.wb_dat_i = 32'h0;
  endtask

  task automatic drive(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] wdat);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_sel_i = sel;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = wdat;
  endtask

  // Called 1ns after a rising edge with the DUT idle; returns the same way.
  task automatic xfer(input string tag, input bit we, input logic [3:0] sel,
                      input logic [7:0] idx);
    logic [31:0] adr, wdat, exp_rd;
    adr    = BASE + {22'd0, idx, 2'b00};
    wdat   = $urandom;
    exp_rd = ref_mem[idx];
    drive(we, sel, adr, wdat);
    #1;
    check({tag, ".en"}, {31'd0, ram_en0}, 32'd1);
    check({tag, ".a0"}, {24'd0, ram_a0}, {24'd0, idx});
    check({tag, ".we0"}, {28'd0, ram_we0}, we ? {28'd0, sel} : 32'd0);
    if (we) check({tag, ".di0"}, ram_di0, wdat);
    check({tag, ".ack_early"}, {31'd0, wb.wb_ack_o}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".ack"}, {31'd0, wb.wb_ack_o}, 32'd1);
    check({tag, ".dat"}, wb.wb_dat_o, we ? 32'd0 : exp_rd);
    check({tag, ".en_in_ack"}, {31'd0, ram_en0}, 32'd0);
    if (we) begin
      ref_mem[idx] = merge(ref_mem[idx], wdat, sel);
      ref_ok[idx]  = 1'b1;
    end
    idle_bus();
    @(posedge clk); #1;
    check({tag, ".ack_end"}, {31'd0, wb.wb_ack_o}, 32'd0);
    check({tag, ".dat_idle"}, wb.wb_dat_o, 32'd0);
  endtask

  task automatic write_word(input string tag, input logic [7:0] idx, input logic [31:0] d,
                            input logic [3:0] sel);
    drive(1'b1, sel, BASE + {22'd0, idx, 2'b00}, d);
    #1;
    check({tag, ".en"}, {31'd0, ram_en0}, 32'd1);
    check({tag, ".a0"}, {24'd0, ram_a0}, {24'd0, idx});
    check({tag, ".we0"}, {28'd0, ram_we0}, {28'd0, sel});
    @(posedge clk); #1;
    check({tag, ".ack"}, {31'd0, wb.wb_ack_o}, 32'd1);
    check({tag, ".dat"}, wb.wb_dat_o, 32'd0);
    ref_mem[idx] = merge(ref_mem[idx], d, sel);
    ref_ok[idx]  = 1'b1;
    idle_bus();
    @(posedge clk); #1;
  endtask

`ifdef RAM256_WB_ZERO_INIT_EN
  // Follows the zero-fill sweep; returns cycles until init_done rises.
  task automatic watch_init(output int n, output int bad, output int acks);
    n = 0; bad = 0; acks = 0;
    while (!init_done && n < 400) begin
      if (ram_en0 !== 1'b1 || ram_a0 !== n[7:0] || ram_we0 !== 4'hF || ram_di0 !== 32'd0)
        bad++;
      if (wb.wb_ack_o !== 1'b0) acks++;
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 32'd0;
      ref_ok[i]  = 1'b1;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, acks;
    logic [7:0]  idx;
    logic [3:0]  sel;
    bit          we;
    logic [31:0] d0, d255;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 32'd0;
      ref_ok[i]  = 1'b0;
    end
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("rst.dat", wb.wb_dat_o, 32'd0);
    check("rst.en0", {31'd0, ram_en0}, 32'd0);
    check("rst.we0", {28'd0, ram_we0}, 32'd0);
    check("rst.a0", {24'd0, ram_a0}, 32'd0);
    check("rst.di0", ram_di0, 32'd0);
`ifdef RAM256_WB_ZERO_INIT_EN
    check("rst.init_done", {31'd0, init_done}, 32'd0);
    rst = 1'b0;
    // Read of word 7 posted immediately; it must wait out the sweep
    drive(1'b0, 4'hF, BASE + 32'h1C, 32'h0);
    #1;
    watch_init(n, bad, acks);
    check("init.cycles", n, 32'd256);
    check("init.sweep", bad, 32'd0);
    check("init.no_ack", acks, 32'd0);
    check("init.w7_en", {31'd0, ram_en0}, 32'd1);
    check("init.w7_a0", {24'd0, ram_a0}, 32'd7);
    check("init.w7_we0", {28'd0, ram_we0}, 32'd0);
    @(posedge clk); #1;
    check("init.w7_ack", {31'd0, wb.wb_ack_o}, 32'd1);
    check("init.w7_dat", wb.wb_dat_o, 32'd0);
    idle_bus();
    @(posedge clk); #1;
`else
    check("rst.init_done", {31'd0, init_done}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
`endif

    // Full word write then readback
    write_word("w_dead", 8'd4, 32'hDEADBEEF, 4'hF);
    xfer("r_dead", 1'b0, 4'hF, 8'd4);
    check("r_dead.model", ref_mem[4], 32'hDEADBEEF);

    // Byte lane write
    write_word("w_1122", 8'd8, 32'h11223344, 4'hF);
    write_word("w_byte", 8'd8, 32'h000000AA, 4'h1);
    xfer("r_byte", 1'b0, 4'hF, 8'd8);
    check("r_byte.model", ref_mem[8], 32'h112233AA);

    // Zero byte-enable write still cycles the RAM but changes nothing
    xfer("w_sel0", 1'b1, 4'h0, 8'd8);
    xfer("r_sel0", 1'b0, 4'hF, 8'd8);

    // Out-of-window access, strobe held five cycles
    drive(1'b0, 4'hF, BASE + 32'h400, 32'h0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ram_en0 !== 1'b0 || wb.wb_ack_o !== 1'b0) n++;
      @(posedge clk); #1;
    end
    check("miss.activity", n, 32'd0);
    idle_bus();

    // Back-to-back reads of words 0 and 255 with strobe held throughout
    d0 = $urandom; d255 = $urandom;
    write_word("w_w0", 8'd0, d0, 4'hF);
    write_word("w_w255", 8'd255, d255, 4'hF);
    drive(1'b0, 4'hF, BASE, 32'h0);
    #1;
    check("b2b.en0", {31'd0, ram_en0}, 32'd1);
    check("b2b.a0_0", {24'd0, ram_a0}, 32'd0);
    @(posedge clk); #1;
    check("b2b.ack0", {31'd0, wb.wb_ack_o}, 32'd1);
    check("b2b.dat0", wb.wb_dat_o, d0);
    check("b2b.no_reissue", {31'd0, ram_en0}, 32'd0);
    wb.wb_adr_i = BASE + 32'h3FC;
    @(posedge clk); #1;
    check("b2b.gap", {31'd0, wb.wb_ack_o}, 32'd0);
    check("b2b.en1", {31'd0, ram_en0}, 32'd1);
    check("b2b.a0_255", {24'd0, ram_a0}, 32'd255);
    @(posedge clk); #1;
    check("b2b.ack1", {31'd0, wb.wb_ack_o}, 32'd1);
    check("b2b.dat1", wb.wb_dat_o, d255);
    idle_bus();
    @(posedge clk); #1;

    // cyc dropped during the ack cycle: write must still stand
    drive(1'b1, 4'hF, BASE + 32'h40, 32'hCAFEF00D);
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    #1;
    check("cycdrop.ack", {31'd0, wb.wb_ack_o}, 32'd1);
    ref_mem[16] = 32'hCAFEF00D; ref_ok[16] = 1'b1;
    idle_bus();
    @(posedge clk); #1;
    xfer("cycdrop.rd", 1'b0, 4'hF, 8'd16);

    // Randomised traffic against the reference memory
    for (int k = 0; k < 40; k++) begin
      idx = 8'($urandom_range(0, 255));
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      if (!ref_ok[idx]) begin
        we  = 1'b1;
        sel = 4'hF;
      end
      xfer(we ? "rnd.wr" : "rnd.rd", we, sel, idx);
    end

    // Reset together with a request: nothing issued, no ack
    drive(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    rst = 1'b1;
    #1;
    check("rstreq.en0", {31'd0, ram_en0}, 32'd0);
    @(posedge clk); #1;
    check("rstreq.ack", {31'd0, wb.wb_ack_o}, 32'd0);
    idle_bus();
    rst = 1'b0;
`ifdef RAM256_WB_ZERO_INIT_EN
    watch_init(n, bad, acks);
    check("reinit1.cycles", n, 32'd256);
`else
    @(posedge clk); #1;
`endif

    // Reset during the ack cycle drops the ack at the next edge
    drive(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    @(posedge clk); #1;
    check("rstack.pre", {31'd0, wb.wb_ack_o}, 32'd1);
    rst = 1'b1;
    idle_bus();
    @(posedge clk); #1;
    check("rstack.ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("rstack.dat", wb.wb_dat_o, 32'd0);
    rst = 1'b0;
`ifdef RAM256_WB_ZERO_INIT_EN
    // Interrupt the sweep at word 100; it must restart from word 0
    repeat (100) @(posedge clk);
    #1;
    check("init100.a0", {24'd0, ram_a0}, 32'd100);
    check("init100.done", {31'd0, init_done}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    watch_init(n, bad, acks);
    check("reinit2.cycles", n, 32'd256);
    check("reinit2.sweep", bad, 32'd0);
    xfer("reinit2.rd", 1'b0, 4'hF, 8'd4);
`else
    @(posedge clk); #1;
    xfer("post_rst.rd", 1'b0, 4'hF, 8'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
